// File: rtl/btb_branch_predictor_if.sv
// Fetch/MEM-side bundle for the BTB predictor: lookup request and prediction,
// resolved-branch update, and the history/statistics taps.
interface btb_branch_predictor_if #(
  parameter int ADDR_W    = 32,
  parameter int GHR_OUT_W = 1,
  parameter int STAT_W    = 16
);
  logic [ADDR_W-1:0]    fetch_pc;
  logic                 pred_hit;
  logic                 pred_taken;
  logic [ADDR_W-1:0]    pred_target;
  logic                 upd_valid;
  logic [ADDR_W-1:0]    upd_pc;
  logic                 upd_taken;
  logic [ADDR_W-1:0]    upd_target;
  logic                 upd_mispredict;
  logic [GHR_OUT_W-1:0] ghr;
  logic [STAT_W-1:0]    branch_count;
  logic [STAT_W-1:0]    mispredict_count;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_hit, pred_taken, pred_target, ghr, branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target, ghr, branch_count, mispredict_count
  );
endinterface

// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters and optional gshare
// indexing; zero-latency lookup, update on the resolving edge.
module btb_branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 0,
  parameter int STAT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  btb_branch_predictor_if.slave bus
);
  localparam int IDX_W     = $clog2(ENTRIES);
  localparam int TAG_W     = ADDR_W - IDX_W - 2;
  localparam int GHR_OUT_W = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("btb_branch_predictor: ENTRIES must be a power of two >= 2");
  end
  if ((GHR_W < 0) || (GHR_W > IDX_W)) begin : g_bad_ghr
    $error("btb_branch_predictor: GHR_W must be in 0..IDX_W");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("btb_branch_predictor: CNT_W must be >= 1");
  end

  logic                 valid_all  [ENTRIES];
  logic [TAG_W-1:0]     tag_all    [ENTRIES];
  logic [ADDR_W-1:0]    target_all [ENTRIES];
  logic [CNT_W-1:0]     cnt_all    [ENTRIES];

  logic [GHR_OUT_W-1:0] ghr_q;
  logic [IDX_W-1:0]     ghr_idx;
  logic [STAT_W-1:0]    branch_count_q;
  logic [STAT_W-1:0]    mispredict_count_q;

  if (GHR_W > 0) begin : g_ghr_idx
    assign ghr_idx = IDX_W'(ghr_q);
  end else begin : g_no_ghr_idx
    assign ghr_idx = '0;
  end

  // Lookup path
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             lookup_hit;
  logic             lookup_taken;

  assign fetch_idx    = bus.fetch_pc[IDX_W+1:2] ^ ghr_idx;
  assign fetch_tag    = bus.fetch_pc[ADDR_W-1:IDX_W+2];
  assign lookup_hit   = valid_all[fetch_idx] && (tag_all[fetch_idx] == fetch_tag);
  assign lookup_taken = lookup_hit && cnt_all[fetch_idx][CNT_W-1];

  assign bus.pred_hit    = lookup_hit;
  assign bus.pred_taken  = lookup_taken;
  assign bus.pred_target = lookup_taken ? target_all[fetch_idx]
                                        : bus.fetch_pc + ADDR_W'(4);

  // Update path, indexed with the history as it stood before this edge
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CNT_W-1:0] cnt_upd_d;

  assign upd_idx = bus.upd_pc[IDX_W+1:2] ^ ghr_idx;
  assign upd_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_hit = valid_all[upd_idx] && (tag_all[upd_idx] == upd_tag);

  always_comb begin
    cnt_upd_d = cnt_all[upd_idx];
    if (bus.upd_taken) begin
      if (cnt_all[upd_idx] != CNT_MAX) cnt_upd_d = cnt_all[upd_idx] + CNT_W'(1);
    end else begin
      if (cnt_all[upd_idx] != '0) cnt_upd_d = cnt_all[upd_idx] - CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic              valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic [ADDR_W-1:0] target_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              entry_we;

    assign entry_we = bus.upd_valid && (upd_idx == IDX_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q  <= 1'b0;
        tag_q    <= '0;
        target_q <= '0;
        cnt_q    <= CNT_WNT;
      end else if (entry_we) begin
        if (upd_hit) begin
          cnt_q <= cnt_upd_d;
          if (bus.upd_taken) target_q <= bus.upd_target;
        end else if (bus.upd_taken) begin
          // A taken miss claims the slot, evicting any alias
          valid_q  <= 1'b1;
          tag_q    <= upd_tag;
          target_q <= bus.upd_target;
          cnt_q    <= CNT_WT;
        end
      end
    end

    assign valid_all[gi]  = valid_q;
    assign tag_all[gi]    = tag_q;
    assign target_all[gi] = target_q;
    assign cnt_all[gi]    = cnt_q;
  end

  // Non-speculative history: shifts only on resolved branches
  if (GHR_W > 1) begin : g_ghr_shift
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                ghr_q <= '0;
      else if (bus.upd_valid) ghr_q <= {ghr_q[GHR_W-2:0], bus.upd_taken};
    end
  end else if (GHR_W == 1) begin : g_ghr_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                ghr_q <= '0;
      else if (bus.upd_valid) ghr_q <= bus.upd_taken;
    end
  end else begin : g_ghr_none
    assign ghr_q = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bus.upd_valid) begin
      if (branch_count_q != '1) branch_count_q <= branch_count_q + STAT_W'(1);
      if (bus.upd_mispredict && (mispredict_count_q != '1))
        mispredict_count_q <= mispredict_count_q + STAT_W'(1);
    end
  end

  assign bus.ghr              = ghr_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, bus.fetch_pc[1:0], bus.upd_pc[1:0]};
endmodule

// File: tb/tb_btb_branch_predictor.sv
// Bench for btb_branch_predictor: a bimodal and a gshare instance share one
// stimulus stream and are checked against an array-based reference model.
module tb_btb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  btb_branch_predictor_if #(.ADDR_W(32), .GHR_OUT_W(1), .STAT_W(16)) bus0 ();
  btb_branch_predictor_if #(.ADDR_W(32), .GHR_OUT_W(2), .STAT_W(8))  bus1 ();

  btb_branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2), .GHR_W(0), .STAT_W(16))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  btb_branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2), .GHR_W(2), .STAT_W(8))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference model: d=0 bimodal (16-bit stats), d=1 gshare with 2-bit history (8-bit stats)
  bit          mvalid [2][16];
  logic [31:0] mtag   [2][16];
  logic [31:0] mtgt   [2][16];
  int          mcnt   [2][16];
  int          mghr   [2];
  int          mbc    [2];
  int          mmc    [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        mvalid[d][i] = 1'b0;
        mtag[d][i]   = '0;
        mtgt[d][i]   = '0;
        mcnt[d][i]   = 1;
      end
      mghr[d] = 0;
      mbc[d]  = 0;
      mmc[d]  = 0;
    end
  endtask

  task automatic model_pred(input int d, input logic [31:0] pc,
                            output bit h, output bit t, output logic [31:0] tg);
    int i;
    i  = int'((pc >> 2) & 32'd15) ^ mghr[d];
    h  = mvalid[d][i] && (mtag[d][i] == (pc >> 6));
    t  = h && (mcnt[d][i] >= 2);
    tg = t ? mtgt[d][i] : pc + 32'd4;
  endtask

  task automatic model_upd(input int d, input logic [31:0] pc, input bit t,
                           input logic [31:0] tg, input bit mis);
    int i;
    int smax;
    i    = int'((pc >> 2) & 32'd15) ^ mghr[d];
    smax = (d == 0) ? 65535 : 255;
    if (mvalid[d][i] && (mtag[d][i] == (pc >> 6))) begin
      if (t) begin
        mcnt[d][i] = (mcnt[d][i] < 3) ? mcnt[d][i] + 1 : 3;
        mtgt[d][i] = tg;
      end else begin
        mcnt[d][i] = (mcnt[d][i] > 0) ? mcnt[d][i] - 1 : 0;
      end
    end else if (t) begin
      mvalid[d][i] = 1'b1;
      mtag[d][i]   = pc >> 6;
      mtgt[d][i]   = tg;
      mcnt[d][i]   = 2;
    end
    if (d == 1) mghr[1] = ((mghr[1] << 1) | int'(t)) & 3;
    if (mbc[d] < smax) mbc[d] = mbc[d] + 1;
    if (mis && (mmc[d] < smax)) mmc[d] = mmc[d] + 1;
  endtask

  task automatic check_model();
    bit h;
    bit t;
    logic [31:0] tg;
    model_pred(0, bus0.fetch_pc, h, t, tg);
    chk("d0_hit",    64'(bus0.pred_hit),         64'(h));
    chk("d0_taken",  64'(bus0.pred_taken),       64'(t));
    chk("d0_target", 64'(bus0.pred_target),      64'(tg));
    chk("d0_ghr",    64'(bus0.ghr),              64'(mghr[0]));
    chk("d0_bcnt",   64'(bus0.branch_count),     64'(mbc[0]));
    chk("d0_mcnt",   64'(bus0.mispredict_count), 64'(mmc[0]));
    model_pred(1, bus1.fetch_pc, h, t, tg);
    chk("d1_hit",    64'(bus1.pred_hit),         64'(h));
    chk("d1_taken",  64'(bus1.pred_taken),       64'(t));
    chk("d1_target", 64'(bus1.pred_target),      64'(tg));
    chk("d1_ghr",    64'(bus1.ghr),              64'(mghr[1]));
    chk("d1_bcnt",   64'(bus1.branch_count),     64'(mbc[1]));
    chk("d1_mcnt",   64'(bus1.mispredict_count), 64'(mmc[1]));
  endtask

  task automatic drive(input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utgt, input bit um);
    bus0.fetch_pc = fpc;  bus1.fetch_pc = fpc;
    bus0.upd_valid = uv;  bus1.upd_valid = uv;
    bus0.upd_pc = upc;    bus1.upd_pc = upc;
    bus0.upd_taken = ut;  bus1.upd_taken = ut;
    bus0.upd_target = utgt; bus1.upd_target = utgt;
    bus0.upd_mispredict = um; bus1.upd_mispredict = um;
  endtask

  // One cycle: outputs checked mid-cycle against pre-edge model, then model advances with the edge
  task automatic step(input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit um);
    drive(fpc, uv, upc, ut, utgt, um);
    @(negedge clk);
    check_model();
    if (uv) begin
      model_upd(0, upc, ut, utgt, um);
      model_upd(1, upc, ut, utgt, um);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic peek0(input string tag, input logic [31:0] fpc,
                       input bit h, input bit t, input logic [31:0] tg);
    bus0.fetch_pc = fpc;
    #1;
    chk({tag, "_hit"},    64'(bus0.pred_hit),    64'(h));
    chk({tag, "_taken"},  64'(bus0.pred_taken),  64'(t));
    chk({tag, "_target"}, 64'(bus0.pred_target), 64'(tg));
  endtask

  task automatic peek1(input string tag, input logic [31:0] fpc,
                       input bit h, input bit t, input logic [31:0] tg);
    bus1.fetch_pc = fpc;
    #1;
    chk({tag, "_hit"},    64'(bus1.pred_hit),    64'(h));
    chk({tag, "_taken"},  64'(bus1.pred_taken),  64'(t));
    chk({tag, "_target"}, 64'(bus1.pred_target), 64'(tg));
  endtask

  logic [31:0] pool [8];

  initial begin
    pool[0] = 32'h40;  pool[1] = 32'h80;  pool[2] = 32'hC0;   pool[3] = 32'h00;
    pool[4] = 32'h08;  pool[5] = 32'h0C;  pool[6] = 32'h100;  pool[7] = 32'h1040;
    model_reset();
    drive(32'h40, 1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    peek0("rst0", 32'h40, 1'b0, 1'b0, 32'h44);
    chk("rst0_bcnt", 64'(bus0.branch_count), 64'd0);
    chk("rst0_mcnt", 64'(bus0.mispredict_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Allocation and counter saturation on the bimodal instance
    step(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    peek0("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    chk("alloc_bcnt", 64'(bus0.branch_count), 64'd1);
    repeat (3) step(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    step(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    peek0("sat_nt1", 32'h40, 1'b1, 1'b1, 32'h100);
    step(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    peek0("sat_nt2", 32'h40, 1'b1, 1'b0, 32'h44);

    // Aliasing at index 0
    step(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    step(32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0);
    peek0("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
    peek0("alias_new", 32'h80, 1'b1, 1'b1, 32'h200);

    // Same-cycle lookup and update of one entry at WT
    step(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    peek0("same_pre", 32'h40, 1'b1, 1'b1, 32'h100);
    step(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    peek0("same_post", 32'h40, 1'b1, 1'b0, 32'h44);

    // Asynchronous reset mid-run, checked before any clock edge
    #2;
    rst = 1'b1;
    #1;
    peek0("arst", 32'h40, 1'b0, 1'b0, 32'h44);
    chk("arst_bcnt", 64'(bus0.branch_count), 64'd0);
    chk("arst_mcnt", 64'(bus0.mispredict_count), 64'd0);
    chk("arst_d1_mcnt", 64'(bus1.mispredict_count), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(32'h40, 1'b0, 32'h40, 1'b1, 32'h999, 1'b1);

    // gshare: build history 2'b10, allocate idx 2 from pc 0x00
    step(32'h500, 1'b1, 32'h500, 1'b1, 32'h700, 1'b0);
    step(32'h504, 1'b1, 32'h504, 1'b0, 32'h0, 1'b0);
    chk("gs_ghr", 64'(bus1.ghr), 64'b10);
    step(32'h00, 1'b1, 32'h00, 1'b1, 32'h300, 1'b0);
    step(32'h600, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    chk("gs_ghr2", 64'(bus1.ghr), 64'b10);
    bus1.upd_valid = 1'b0;
    peek1("gs_f08", 32'h08, 1'b0, 1'b0, 32'h0C);
    peek1("gs_f00", 32'h00, 1'b1, 1'b1, 32'h300);

    // Randomized traffic, every update flagged as a mispredict
    for (int n = 0; n < 300; n++) begin
      logic [31:0] upc;
      logic [31:0] fpc;
      logic [31:0] tgt;
      upc = pool[$urandom_range(7)];
      fpc = pool[$urandom_range(7)];
      tgt = {$urandom_range(32'h3FFF), 2'b00};
      step(fpc, 1'b1, upc, 1'($urandom_range(1)), tgt, 1'b1);
    end
    for (int n = 0; n < 20; n++) begin
      step(pool[$urandom_range(7)], 1'($urandom_range(1)), pool[$urandom_range(7)],
           1'($urandom_range(1)), 32'h4000, 1'b0);
    end
    chk("stat_mcnt_sat", 64'(bus1.mispredict_count), 64'd255);
    chk("stat_bcnt_sat", 64'(bus1.branch_count), 64'd255);
    chk("stat_d0_mcnt", 64'(bus0.mispredict_count), 64'd300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
